// File: rtl/res_seq_pkg.sv
// Shared types and constants for the res_seq reset sequencer.
// Holds the state encoding, reset-cause codes and small counter helpers.
package res_seq_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RUN   = 2'd1,
    PRESS = 2'd2
  } state_t;

  localparam logic [1:0] RES_POR    = 2'b00;
  localparam logic [1:0] RES_BTN    = 2'b01;
  localparam logic [1:0] RES_CLKSET = 2'b10;
  localparam logic [1:0] RES_WDT    = 2'b11;

  localparam logic [7:0] RES_COUNT_MAX = 8'hFF;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == RES_COUNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/res_debounce.sv
// Reset-button conditioner: 2-flop synchroniser into a level debouncer.
// btn_db only moves once the synchronised level has differed for DB_LEN cycles.
module res_debounce
  import res_seq_pkg::*;
#(
  parameter int DB_LEN = 16
) (
  input  logic clk_cog,
  input  logic nres,
  input  logic btn_n,
  output logic btn_db
);

  localparam int              CW      = cnt_w(DB_LEN);
  localparam logic [CW-1:0]   DB_LAST = CW'(DB_LEN - 1);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] db_cnt;

  // Idle level of the button is high, so the chain resets to 1.
  always_ff @(posedge clk_cog or negedge nres) begin
    if (!nres) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
    end else begin
      sync_1 <= btn_n;
      sync_2 <= sync_1;
    end
  end

  always_ff @(posedge clk_cog or negedge nres) begin
    if (!nres) begin
      btn_db <= 1'b1;
      db_cnt <= '0;
    end else if (sync_2 != btn_db) begin
      if (db_cnt == DB_LAST) begin
        btn_db <= sync_2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + CW'(1);
      end
    end else begin
      db_cnt <= '0;
    end
  end

endmodule

// File: rtl/res_seq.sv
// Reset sequencer for the digital core: merges power-on, button, clkset and
// watchdog requests into a minimum-width inp_res. Watchdog built only with RES_SEQ_WDT_EN.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   HOLD  | inp_res high, counting HOLD_LEN cycles before release
//   RUN   | core running, watching button / watchdog / clkset requests
//   PRESS | inp_res high while the debounced button stays pressed
module res_seq
  import res_seq_pkg::*;
#(
  parameter int DB_LEN   = 16,
  parameter int HOLD_LEN = 1024,
  parameter int WDT_BITS = 24
) (
  input  logic       clk_cog,
  input  logic       nres,
  input  logic       btn_n,
  input  logic       cfg7,
  input  logic       wdt_kick,
  output logic       inp_res,
  output logic [1:0] res_cause,
  output logic [7:0] res_count
);

  localparam int            HC_W      = cnt_w(HOLD_LEN);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_LEN - 1);

  state_t          state;
  state_t          state_d;
  logic [HC_W-1:0] hold_cnt;
  logic [HC_W-1:0] hold_cnt_d;
  logic [1:0]      cause_d;
  logic            count_inc;
  logic            btn_db;
  logic            cfg7_q;
  logic            cfg7_rise;
  logic            wdt_expire;

  res_debounce #(
    .DB_LEN (DB_LEN)
  ) u_debounce (
    .clk_cog (clk_cog),
    .nres    (nres),
    .btn_n   (btn_n),
    .btn_db  (btn_db)
  );

  // cfg7 already comes from a register in this clock domain.
  assign cfg7_rise = cfg7 & ~cfg7_q;

`ifdef RES_SEQ_WDT_EN
  logic [WDT_BITS-1:0] wdt_cnt;

  always_ff @(posedge clk_cog or negedge nres) begin
    if (!nres) begin
      wdt_cnt <= '0;
    end else if (wdt_kick || (state != RUN)) begin
      wdt_cnt <= '0;
    end else begin
      wdt_cnt <= wdt_cnt + WDT_BITS'(1);
    end
  end

  // A kick landing on the expiry cycle rescues the core.
  assign wdt_expire = (state == RUN) && (wdt_cnt == '1) && !wdt_kick;
`else
  logic [WDT_BITS-1:0] unused_wdt;

  assign unused_wdt = {WDT_BITS{wdt_kick}};
  assign wdt_expire = 1'b0;
`endif

  // Hold counter defaults to zero so every entry into HOLD starts fresh.
  always_comb begin
    state_d    = state;
    hold_cnt_d = '0;
    cause_d    = res_cause;
    count_inc  = 1'b0;
    unique case (state)
      HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          state_d = RUN;
        end else begin
          hold_cnt_d = hold_cnt + HC_W'(1);
        end
      end
      RUN: begin
        if (!btn_db) begin
          state_d   = PRESS;
          cause_d   = RES_BTN;
          count_inc = 1'b1;
        end else if (wdt_expire) begin
          state_d   = HOLD;
          cause_d   = RES_WDT;
          count_inc = 1'b1;
        end else if (cfg7_rise) begin
          state_d   = HOLD;
          cause_d   = RES_CLKSET;
          count_inc = 1'b1;
        end
      end
      PRESS: begin
        if (btn_db) begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = HOLD;
      end
    endcase
  end

  always_ff @(posedge clk_cog or negedge nres) begin
    if (!nres) begin
      state     <= HOLD;
      hold_cnt  <= '0;
      inp_res   <= 1'b1;
      res_cause <= RES_POR;
      res_count <= '0;
      cfg7_q    <= 1'b0;
    end else begin
      state     <= state_d;
      hold_cnt  <= hold_cnt_d;
      inp_res   <= (state_d != RUN);
      res_cause <= cause_d;
      if (count_inc) begin
        res_count <= sat_inc8(res_count);
      end
      cfg7_q    <= cfg7;
    end
  end

endmodule

// File: tb/tb_res_seq.sv
// Scoreboard bench for res_seq (DB_LEN=4, HOLD_LEN=8, WDT_BITS=4).
// Stimulus pushes expected inp_res edges; a monitor pops them on every inp_res change.
module tb_res_seq;

  localparam int DB_LEN   = 4;
  localparam int HOLD_LEN = 8;
  localparam int WDT_BITS = 4;

  typedef struct {
    int         cyc;
    logic       val;
    logic [1:0] cause;
    logic [7:0] count;
  } exp_t;

  logic       clk;
  logic       nres;
  logic       btn_n;
  logic       cfg7;
  logic       wdt_kick;
  logic       inp_res;
  logic [1:0] res_cause;
  logic [7:0] res_count;

  int   cyc;
  int   n_checks;
  int   n_fail;
  exp_t q[$];
  logic [7:0] exp_count;

  res_seq #(
    .DB_LEN   (DB_LEN),
    .HOLD_LEN (HOLD_LEN),
    .WDT_BITS (WDT_BITS)
  ) dut (
    .clk_cog   (clk),
    .nres      (nres),
    .btn_n     (btn_n),
    .cfg7      (cfg7),
    .wdt_kick  (wdt_kick),
    .inp_res   (inp_res),
    .res_cause (res_cause),
    .res_count (res_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic push(input int c, input logic v, input logic [1:0] ca, input logic [7:0] cn);
    exp_t e;
    e.cyc   = c;
    e.val   = v;
    e.cause = ca;
    e.count = cn;
    q.push_back(e);
  endtask

  function automatic logic [7:0] inc8(input logic [7:0] v);
    return (v == 8'd255) ? 8'd255 : v + 8'd1;
  endfunction

  // Monitor: every change of inp_res must match the head of the queue.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (!nres) begin
        prev = inp_res;
      end else if (inp_res !== prev) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_edge: inp_res=%0b at cycle %0d, required no change", inp_res, cyc);
        end else begin
          e = q.pop_front();
          check("edge_cycle", cyc, e.cyc);
          check("edge_level", {31'd0, inp_res}, {31'd0, e.val});
          check("edge_cause", {30'd0, res_cause}, {30'd0, e.cause});
          check("edge_count", {24'd0, res_count}, {24'd0, e.count});
        end
        prev = inp_res;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    logic glitch_low;
    int   b;
    cyc       = 0;
    n_checks  = 0;
    n_fail    = 0;
    exp_count = 8'd0;
    nres      = 1'b0;
    btn_n     = 1'b1;
    cfg7      = 1'b0;
    wdt_kick  = 1'b1;

    // Reset values while nres is low
    wait_to(2);
    check("rst_inp_res", {31'd0, inp_res}, 32'd1);
    check("rst_cause", {30'd0, res_cause}, 32'd0);
    check("rst_count", {24'd0, res_count}, 32'd0);
    check("rst_btn_db", {31'd0, dut.btn_db}, 32'd1);

    // Power-on: release after edge 3, falls HOLD_LEN edges later
    wait_to(3);
    push(3 + HOLD_LEN, 1'b0, 2'b00, 8'd0);
    nres = 1'b1;

    // Button: first sampled at edge 21, rise at 21+DB_LEN+2; release first sampled at 31
    wait_to(20);
    btn_n = 1'b0;
    exp_count = inc8(exp_count);
    push(21 + DB_LEN + 2, 1'b1, 2'b01, exp_count);
    wait_to(30);
    btn_n = 1'b1;
    push(31 + DB_LEN + 2 + HOLD_LEN, 1'b0, 2'b01, exp_count);

    // Glitch of 3 cycles: nothing may move
    wait_to(60);
    btn_n = 1'b0;
    glitch_low = 1'b0;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      if (dut.btn_db !== 1'b1) glitch_low = 1'b1;
      if (j == 2) btn_n = 1'b1;
    end
    check("glitch_btn_db_low", {31'd0, glitch_low}, 32'd0);
    check("glitch_count", {24'd0, res_count}, {24'd0, exp_count});

    // Clkset pulse, then cfg7 held high: exactly one reset
    wait_to(80);
    cfg7 = 1'b1;
    exp_count = inc8(exp_count);
    push(81, 1'b1, 2'b10, exp_count);
    push(81 + HOLD_LEN, 1'b0, 2'b10, exp_count);
    wait_to(110);
    cfg7 = 1'b0;

    // Debounced button fall and cfg7 rise seen on the same edge (127)
    wait_to(120);
    btn_n = 1'b0;
    wait_to(126);
    cfg7 = 1'b1;
    exp_count = inc8(exp_count);
    push(127, 1'b1, 2'b01, exp_count);
    wait_to(135);
    btn_n = 1'b1;
    push(150, 1'b0, 2'b01, exp_count);
    wait_to(160);
    cfg7 = 1'b0;

    // Watchdog: kicks every 10 cycles, then starvation
    wait_to(170);
    wdt_kick = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_to(170 + 10 * i + 9);
      wdt_kick = 1'b1;
      wait_to(170 + 10 * i + 10);
      wdt_kick = 1'b0;
    end
`ifdef RES_SEQ_WDT_EN
    exp_count = inc8(exp_count);
    push(236, 1'b1, 2'b11, exp_count);
    push(236 + HOLD_LEN, 1'b0, 2'b11, exp_count);
`endif
    wait_to(260);
    wdt_kick = 1'b1;

    // Many clkset resets: res_count must saturate at 255
    b = 270;
    for (int i = 0; i < 260; i++) begin
      wait_to(b);
      cfg7 = 1'b1;
      exp_count = inc8(exp_count);
      push(b + 1, 1'b1, 2'b10, exp_count);
      push(b + 1 + HOLD_LEN, 1'b0, 2'b10, exp_count);
      wait_to(b + 1);
      cfg7 = 1'b0;
      b += 12;
    end
    wait_to(b - 1);
    check("sat_count", {24'd0, res_count}, 32'd255);

    // nres asserted mid-HOLD: immediate return to reset values
    wait_to(b);
    cfg7 = 1'b1;
    push(b + 1, 1'b1, 2'b10, 8'd255);
    wait_to(b + 1);
    cfg7 = 1'b0;
    wait_to(b + 4);
    #2;
    nres = 1'b0;
    #1;
    check("mid_rst_cause", {30'd0, res_cause}, 32'd0);
    check("mid_rst_count", {24'd0, res_count}, 32'd0);
    check("mid_rst_inp_res", {31'd0, inp_res}, 32'd1);
    wait_to(b + 6);
    push(b + 6 + HOLD_LEN, 1'b0, 2'b00, 8'd0);
    nres = 1'b1;

    wait_to(b + 40);
    check("queue_empty", q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
